rr_arb_mux: RTL and testbench
=============================

Name: rr_arb_mux

Overview:
- Parametrised N-channel, W-bit round-robin arbitrating multiplexer with a valid/ready handshake on every input and on the output.
- Successor to the single-bit 2:1 combinational mux and mux-built gates. It adds arbitration, backpressure and a registered output stage.
- Sits between several producer streams and one shared consumer, for example merging request queues into one downstream pipe.

Parameters:
- N_CH, 4, number of input channels (2..16).
- W, 8, data width in bits (1..64).
- CH_W, $clog2(N_CH), width of the channel-index output; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  N_CH  per-channel data valid
- in_data  input  N_CH*W  packed data; channel i occupies bits [i*W +: W]
- in_ready  output  N_CH  per-channel accept; at most one bit high per cycle
- out_valid  output  1  output register holds a word
- out_data  output  W  registered selected data
- out_ch  output  CH_W  index of the channel that supplied out_data
- out_ready  input  1  consumer accept

Behaviour:
- Reset (async assert, sync deassert handled upstream): out_valid=0, out_data=0, out_ch=0, rr pointer ptr=0. Any held word is discarded; no partial transfer survives reset.
- Interface: clock clk, reset rst_n, asynchronous active-low.
- Output stage holds one word.
  - can_load = !out_valid | out_ready.
- Grant:
  - Search in_valid starting at index ptr, ascending, wrapping N_CH-1 -> 0.
  - The first set bit is the winner g. It is combinational from in_valid and ptr.
  - in_ready[g] = can_load & any(in_valid); all other in_ready bits = 0.
  - in_ready may depend combinationally on in_valid and out_ready; producers must not make in_valid depend on in_ready.
- Transfer into output: on the clk edge with in_valid[g] & in_ready[g], out_data<=in_data[g], out_ch<=g, out_valid<=1, ptr<=(g+1) mod N_CH.
  - Latency is 1 cycle input-to-output.
  - Throughput is 1 word/cycle when out_ready is held high.
- Output drain: out_valid & out_ready with no new load -> out_valid<=0. out_data and out_ch hold their last values.
- Simultaneous drain and load in the same cycle: the new word replaces the old one, out_valid stays 1, and no bubble is inserted.
- Stall: out_valid & !out_ready -> all in_ready=0. out_data, out_ch and ptr are stable.
- No valid inputs: ptr unchanged, no load.
- Fairness: with all N_CH inputs continuously valid and out_ready=1, grants cycle 0,1,..,N_CH-1,0,...
  - Worst-case wait for any channel is N_CH-1 accepted words.
- N_CH not a power of 2: ptr increment wraps at N_CH, not at 2^CH_W. out_ch never exceeds N_CH-1.

Optional Feature:
- Macro: RR_ARB_MUX_PKT_LOCK_EN.
- Defined:
  - Adds ports in_last (input, N_CH) and out_last (output, 1). out_last is registered alongside out_data and is 0 at reset.
  - A lock state machine has states IDLE and LOCKED, with the held channel stored in lock_ch.
  - IDLE: on an accepted beat with in_last[g]=0, go to LOCKED with lock_ch=g.
  - LOCKED: only lock_ch may be granted, and other channels see in_ready=0. An accepted beat with in_last[lock_ch]=1 returns to IDLE and sets ptr=(lock_ch+1) mod N_CH.
  - ptr does not advance on non-last beats.
  - Reset forces IDLE.
- Undefined: ports absent; every beat is arbitrated independently, as described above.

Decomposition:
- Package rr_arb_mux_pkg holds:
  - typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;
  - function next_ptr(g, n) implementing the wrap rule.
- Sub-module rr_prio_pick (parameter N). Purely combinational.
  - Inputs: req[N], ptr.
  - Outputs: gnt_onehot[N], gnt_idx, any.
  - Implemented as double-width rotate-and-mask priority encode.
- Data select in rr_arb_mux is a one-hot AND-OR over in_data.

Test Plan:
- Reset mid-stream: out_valid=1 holding 0x5A, assert rst_n=0 -> out_valid=0, out_data=0x00, out_ch=0 immediately; after release, first grant comes from ch0.
- All 4 channels valid (data 0x10,0x11,0x12,0x13), out_ready=1 -> out_ch sequence 0,1,2,3,0,..., one word per cycle, out_data matching the channel.
- Only ch2 valid with 0xA5, out_ready=0 for 3 cycles -> in_ready=0 during the stall, out_data=0xA5 stable; out_ready=1 -> one transfer, then out_valid=0.
- ptr=3 with ch1 and ch3 valid -> ch3 granted, next ptr=0; next cycle ch1 granted.
- N_CH=3 build, all valid -> out_ch sequence 0,1,2,0; out_ch never equals 3.
- RR_ARB_MUX_PKT_LOCK_EN: ch1 sends a 3-beat packet (last on beat 3) while ch0 is valid throughout -> ch1 beats are contiguous, ch0 is granted on the following cycle, and out_last=1 only on beat 3.

Source files
------------

// File: rtl/rr_arb_mux_pkg.sv
// Shared types and helpers for the round-robin arbitrating mux.
package rr_arb_mux_pkg;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

    // Round-robin successor that wraps at n, not at the next power of two.
    function automatic int next_ptr(input int g, input int n);
        return (g + 1 >= n) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational round-robin pick: rotate req so ptr lands at bit 0, take the
// lowest set bit, then rotate the index back.
module rr_prio_pick
    import rr_arb_mux_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt_onehot,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);
    localparam logic [IW:0] NV = (IW+1)'(N);

    logic [N-1:0]  rot;
    logic [IW-1:0] off;
    logic [IW:0]   sum;

    always_comb begin
        rot = N'({req, req} >> ptr);
        off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) off = IW'(k);
        end
        sum        = {1'b0, ptr} + {1'b0, off};
        gnt_idx    = (sum >= NV) ? IW'(sum - NV) : IW'(sum);
        any        = |req;
        gnt_onehot = any ? (N'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel round-robin arbitrating mux with a one-word registered output stage.
// Optional packet locking is enabled with RR_ARB_MUX_PKT_LOCK_EN.
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter  int N_CH = 4,
    parameter  int W    = 8,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   in_valid,
    input  logic [N_CH*W-1:0] in_data,
    output logic [N_CH-1:0]   in_ready,
`ifdef RR_ARB_MUX_PKT_LOCK_EN
    input  logic [N_CH-1:0]   in_last,
    output logic              out_last,
`endif
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic [CH_W-1:0]   out_ch,
    input  logic              out_ready
);
    logic            out_valid_q;
    logic [W-1:0]    out_data_q;
    logic [CH_W-1:0] out_ch_q;
    logic [CH_W-1:0] ptr_q;

    logic            can_load;
    logic            any;
    logic            fire;
    logic [N_CH-1:0] req;
    logic [N_CH-1:0] gnt_oh;
    logic [CH_W-1:0] gnt_idx;
    logic [CH_W-1:0] ptr_inc;
    logic [W-1:0]    sel_data;

    assign can_load = !out_valid_q || out_ready;
    assign fire     = can_load && any;
    assign in_ready = can_load ? gnt_oh : '0;
    assign ptr_inc  = CH_W'(next_ptr(int'(gnt_idx), N_CH));

`ifdef RR_ARB_MUX_PKT_LOCK_EN
    arb_state_e      state_q;
    logic [CH_W-1:0] lock_ch_q;
    logic            out_last_q;
    logic            last_g;

    // While a packet is open only its owner may compete.
    always_comb begin
        req = in_valid;
        if (state_q == ARB_LOCKED) req = in_valid & (N_CH'(1) << lock_ch_q);
    end

    assign last_g   = |(in_last & gnt_oh);
    assign out_last = out_last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            lock_ch_q  <= '0;
            ptr_q      <= '0;
            out_last_q <= 1'b0;
        end else if (fire) begin
            out_last_q <= last_g;
            case (state_q)
                ARB_IDLE: begin
                    if (last_g) begin
                        ptr_q <= ptr_inc;
                    end else begin
                        state_q   <= ARB_LOCKED;
                        lock_ch_q <= gnt_idx;
                    end
                end
                ARB_LOCKED: begin
                    // gnt_idx equals lock_ch_q here since req is masked.
                    if (last_g) begin
                        state_q <= ARB_IDLE;
                        ptr_q   <= ptr_inc;
                    end
                end
            endcase
        end
    end
`else
    assign req = in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    ptr_q <= '0;
        else if (fire) ptr_q <= ptr_inc;
    end
`endif

    rr_prio_pick #(.N(N_CH)) u_pick (
        .req        (req),
        .ptr        (ptr_q),
        .gnt_onehot (gnt_oh),
        .gnt_idx    (gnt_idx),
        .any        (any)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            sel_data |= in_data[i*W +: W] & {W{gnt_oh[i]}};
        end
    end

    // A load in the same cycle as a drain simply overwrites: no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else if (fire) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sel_data;
            out_ch_q    <= gnt_idx;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux: directed scenarios plus a randomized run
// against a spec-level arbitration model (N_CH=4 and N_CH=3 instances).
module tb_rr_arb_mux;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic [3:0]  in_last;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_ready;

    logic [2:0]  v3;
    logic [23:0] d3;
    logic [2:0]  r3;
    logic        ov3;
    logic [7:0]  od3;
    logic [1:0]  oc3;
    logic        or3;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
    logic        out_last;
    logic [2:0]  l3;
    logic        ol3;
`endif

    int checks = 0;
    int errors = 0;

    // reference model state
    logic       m_valid;
    logic [7:0] m_data;
    int         m_ch;
    int         m_ptr;
    bit         m_locked;
    int         m_lock_ch;
    bit         m_last;

    always #5 clk = ~clk;

    rr_arb_mux #(.N_CH(4), .W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
`ifdef RR_ARB_MUX_PKT_LOCK_EN
        .in_last(in_last), .out_last(out_last),
`endif
        .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
        .out_ready(out_ready)
    );

    rr_arb_mux #(.N_CH(3), .W(8)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v3), .in_data(d3), .in_ready(r3),
`ifdef RR_ARB_MUX_PKT_LOCK_EN
        .in_last(l3), .out_last(ol3),
`endif
        .out_valid(ov3), .out_data(od3), .out_ch(oc3),
        .out_ready(or3)
    );

    // Winner: first valid channel at or after p, wrapping; only the owner when locked.
    function automatic int pick(input logic [3:0] v, input int p, input bit locked, input int lc);
        if (locked) return v[lc] ? lc : -1;
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready();
        logic [3:0] r;
        int g;
        r = '0;
        g = pick(in_valid, m_ptr, m_locked, m_lock_ch);
        if (g >= 0 && (!m_valid || out_ready)) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0;
        m_locked = 1'b0; m_lock_ch = 0; m_last = 1'b0;
    endtask

    task automatic model_edge();
        int g;
        g = pick(in_valid, m_ptr, m_locked, m_lock_ch);
        if (g >= 0 && (!m_valid || out_ready)) begin
            m_valid = 1'b1;
            m_data  = in_data[g*8 +: 8];
            m_ch    = g;
            m_last  = in_last[g];
            if (m_locked) begin
                if (in_last[g]) begin m_locked = 1'b0; m_ptr = (g + 1) % 4; end
            end else if (!in_last[g]) begin
                m_locked = 1'b1; m_lock_ch = g;
            end else begin
                m_ptr = (g + 1) % 4;
            end
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic reset_pulse();
        @(negedge clk); rst_n = 1'b0; model_reset();
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_reset();
        in_valid = '0; in_data = '0; out_ready = 1'b0; in_last = '1;
        v3 = '0; d3 = '0; or3 = 1'b1;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
        l3 = '1;
`endif
        model_reset();
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0h want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %0h want 0", out_data); end
        checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL reset_out_ch got %0h want 0", out_ch); end
        @(negedge clk); rst_n = 1'b1;
        in_valid = 4'b0001; in_data = 32'h0000_005A;
        tick();
        in_valid = '0;
        checks++; if ({out_valid, out_data} !== {1'b1, 8'h5A}) begin errors++; $display("FAIL held_5a got %0h want 15a", {out_valid, out_data}); end
        #2 rst_n = 1'b0; #1; model_reset();
        checks++; if ({out_valid, out_ch, out_data} !== 11'h000) begin errors++; $display("FAIL midstream_reset got %0h want 0", {out_valid, out_ch, out_data}); end
        @(negedge clk); rst_n = 1'b1;
        in_valid = 4'b1111; in_data = 32'h1312_1110; out_ready = 1'b1;
        tick();
        checks++; if ({out_ch, out_data} !== {2'd0, 8'h10}) begin errors++; $display("FAIL first_grant_after_reset got %0h want 010", {out_ch, out_data}); end
        in_valid = '0;
        tick();
    endtask

    task automatic test_round_robin();
        reset_pulse();
        in_valid = 4'b1111; in_data = 32'h1312_1110; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++; if (in_ready !== (4'b0001 << (i % 4))) begin errors++; $display("FAIL rr_in_ready[%0d] got %0b want %0b", i, in_ready, 4'b0001 << (i % 4)); end
            tick();
            checks++; if ({out_valid, out_ch, out_data} !== {1'b1, 2'(i % 4), 8'(8'h10 + i % 4)}) begin
                errors++; $display("FAIL rr_seq[%0d] got v=%0b ch=%0d d=%0h want ch=%0d", i, out_valid, out_ch, out_data, i % 4); end
        end
        in_valid = '0;
        tick();
    endtask

    task automatic test_stall();
        in_valid = 4'b0100; in_data = 32'h00A5_0000; out_ready = 1'b0;
        #1;
        checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL stall_first_ready got %0b want 0100", in_ready); end
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready[%0d] got %0b want 0", i, in_ready); end
            tick();
            checks++; if ({out_valid, out_ch, out_data} !== {1'b1, 2'd2, 8'hA5}) begin errors++; $display("FAIL stall_hold[%0d] got ch=%0d d=%0h", i, out_ch, out_data); end
        end
        in_valid = '0; out_ready = 1'b1;
        tick();
        checks++; if ({out_valid, out_data} !== {1'b0, 8'hA5}) begin errors++; $display("FAIL stall_drain got v=%0b d=%0h want v=0 d=a5", out_valid, out_data); end
    endtask

    task automatic test_ptr_wrap();
        in_valid = 4'b0100; in_data = 32'h0077_0000; out_ready = 1'b1;
        tick();
        in_valid = 4'b1010; in_data = 32'hB300_B100;
        #1;
        checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL wrap_ready got %0b want 1000", in_ready); end
        tick();
        checks++; if ({out_ch, out_data} !== {2'd3, 8'hB3}) begin errors++; $display("FAIL wrap_ch3 got ch=%0d d=%0h want 3 b3", out_ch, out_data); end
        checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL wrap_ready2 got %0b want 0010", in_ready); end
        tick();
        checks++; if ({out_ch, out_data} !== {2'd1, 8'hB1}) begin errors++; $display("FAIL wrap_ch1 got ch=%0d d=%0h want 1 b1", out_ch, out_data); end
        in_valid = '0;
        tick();
    endtask

    task automatic test_n3();
        v3 = 3'b111; d3 = 24'h22_2120; or3 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if ({ov3, oc3, od3} !== {1'b1, 2'(i % 3), 8'(8'h20 + i % 3)}) begin
                errors++; $display("FAIL n3_seq[%0d] got v=%0b ch=%0d d=%0h want ch=%0d", i, ov3, oc3, od3, i % 3); end
        end
        v3 = '0;
        tick();
    endtask

    task automatic test_random();
        logic [3:0] er;
        for (int i = 0; i < 300; i++) begin
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(3) != 0);
`ifdef RR_ARB_MUX_PKT_LOCK_EN
            in_last   = 4'($urandom);
`endif
            #1;
            er = exp_ready();
            checks++; if (in_ready !== er) begin errors++; $display("FAIL rand_ready[%0d] got %0b want %0b", i, in_ready, er); end
            tick();
            checks++; if ({out_valid, out_ch, out_data} !== {m_valid, 2'(m_ch), m_data}) begin
                errors++; $display("FAIL rand_out[%0d] got v=%0b ch=%0d d=%0h want v=%0b ch=%0d d=%0h",
                                   i, out_valid, out_ch, out_data, m_valid, m_ch, m_data); end
`ifdef RR_ARB_MUX_PKT_LOCK_EN
            checks++; if (out_last !== m_last) begin errors++; $display("FAIL rand_last[%0d] got %0b want %0b", i, out_last, m_last); end
`endif
        end
        in_valid = '0; out_ready = 1'b1; in_last = '1;
        tick();
    endtask

`ifdef RR_ARB_MUX_PKT_LOCK_EN
    task automatic test_pkt_lock();
        reset_pulse();
        out_ready = 1'b1; in_last = 4'b1111;
        in_valid = 4'b0001; in_data = 32'h0000_0040;
        tick();
        in_valid = 4'b0011;
        for (int b = 1; b <= 3; b++) begin
            in_data = {16'h0, 8'(8'h20 + b), 8'h40};
            in_last = (b == 3) ? 4'b1111 : 4'b1101;
            #1;
            checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL lock_ready[%0d] got %0b want 0010", b, in_ready); end
            tick();
            checks++; if ({out_ch, out_data, out_last} !== {2'd1, 8'(8'h20 + b), (b == 3)}) begin
                errors++; $display("FAIL lock_beat[%0d] got ch=%0d d=%0h last=%0b", b, out_ch, out_data, out_last); end
        end
        in_valid = 4'b0001; in_last = 4'b1111;
        tick();
        checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL lock_release got ch=%0d want 0", out_ch); end
        in_valid = '0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_stall();
        test_ptr_wrap();
        test_n3();
`ifdef RR_ARB_MUX_PKT_LOCK_EN
        test_pkt_lock();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
